// File: rtl/vc_fifo_if.sv
// vc_fifo_if
//   Write/read port bundle of the virtual-channel input buffer.
//   master : switch side; drives write and read requests and observes status.
//   slave  : buffer side; accepts requests and drives data and per-VC status.
//   Signals:
//     wr_en_i, wr_vc_i, data_i   write request, target VC, write data
//     rd_en_i, rd_vc_i           read request, source VC
//     data_o                     read data
//     full_o, empty_o            per-VC full / empty
//     almost_full_o, almost_empty_o  per-VC watermark flags
//     count_o                    per-VC occupancy, packed DEPTH_WIDTH+1 bits per VC
//     overflow_o, underflow_o    per-VC one-cycle rejection pulses
interface vc_fifo_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 2,
  parameter int NUM_VC      = 2,
  parameter int VC_WIDTH    = 1
);
  logic                              wr_en_i;
  logic [VC_WIDTH-1:0]               wr_vc_i;
  logic [DATA_WIDTH-1:0]             data_i;
  logic                              rd_en_i;
  logic [VC_WIDTH-1:0]               rd_vc_i;
  logic [DATA_WIDTH-1:0]             data_o;
  logic [NUM_VC-1:0]                 full_o;
  logic [NUM_VC-1:0]                 empty_o;
  logic [NUM_VC-1:0]                 almost_full_o;
  logic [NUM_VC-1:0]                 almost_empty_o;
  logic [NUM_VC*(DEPTH_WIDTH+1)-1:0] count_o;
  logic [NUM_VC-1:0]                 overflow_o;
  logic [NUM_VC-1:0]                 underflow_o;

  modport master (
    output wr_en_i, wr_vc_i, data_i, rd_en_i, rd_vc_i,
    input  data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, wr_vc_i, data_i, rd_en_i, rd_vc_i,
    output data_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/vc_fifo.sv
// vc_fifo
//   Virtual-channel input buffer: NUM_VC independent circular FIFOs of
//   2**DEPTH_WIDTH entries sharing one write port and one read port.
//   FWFT=0 registers read data; FWFT=1 shows the head of rd_vc_i directly.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  synchronous reset, active high
//     bus    vc_fifo_if slave modport (requests in, data and per-VC status out)
module vc_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH_WIDTH        = 2,
  parameter int NUM_VC             = 2,
  parameter int VC_WIDTH           = 1,
  parameter int ALMOST_EMPTY_LEVEL = 1,
  parameter int ALMOST_FULL_LEVEL  = 3,
  parameter bit FWFT               = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  vc_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int CW    = DEPTH_WIDTH + 1;

  logic [DATA_WIDTH-1:0]  mem    [NUM_VC][DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr [NUM_VC];
  logic [DEPTH_WIDTH-1:0] rd_ptr [NUM_VC];
  logic [CW-1:0]          count  [NUM_VC];

  logic [NUM_VC-1:0]      wr_hit, rd_hit, wr_acc, rd_acc;
  logic [NUM_VC-1:0]      ovf_q, unf_q;
  logic [DATA_WIDTH-1:0]  head;

  // VC indices outside 0..NUM_VC-1 match no channel, so they are dropped
  // without any state change or flag. head is forced to zero for an empty VC.
  always_comb begin
    wr_hit = '0;
    rd_hit = '0;
    wr_acc = '0;
    rd_acc = '0;
    head   = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_hit[v] = bus.wr_en_i && (bus.wr_vc_i == VC_WIDTH'(v));
      rd_hit[v] = bus.rd_en_i && (bus.rd_vc_i == VC_WIDTH'(v));
      rd_acc[v] = rd_hit[v] && (count[v] != '0);
      // A full VC still takes a write when the same VC is popped this cycle.
      wr_acc[v] = wr_hit[v] && ((count[v] != CW'(DEPTH)) || rd_acc[v]);
      if ((bus.rd_vc_i == VC_WIDTH'(v)) && (count[v] != '0)) begin
        head = mem[v][rd_ptr[v]];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_acc[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (rd_acc[v]) rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if (wr_acc[v] && !rd_acc[v]) begin
          count[v] <= count[v] + 1'b1;
        end else if (!wr_acc[v] && rd_acc[v]) begin
          count[v] <= count[v] - 1'b1;
        end
      end
      ovf_q <= wr_hit & ~wr_acc;
      unf_q <= rd_hit & ~rd_acc;
    end
  end

  // Storage has no reset; contents are unobservable while a VC is empty.
  always_ff @(posedge clk_i) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (!rst_i && wr_acc[v]) mem[v][wr_ptr[v]] <= bus.data_i;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.data_o = head;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          data_q <= '0;
        end else if (|rd_acc) begin
          data_q <= head;
        end
      end
      assign bus.data_o = data_q;
    end
  endgenerate

  always_comb begin
    bus.full_o         = '0;
    bus.empty_o        = '0;
    bus.almost_full_o  = '0;
    bus.almost_empty_o = '0;
    bus.count_o        = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      bus.full_o[v]         = (count[v] == CW'(DEPTH));
      bus.empty_o[v]        = (count[v] == '0);
      bus.almost_full_o[v]  = (count[v] >= CW'(ALMOST_FULL_LEVEL));
      bus.almost_empty_o[v] = (count[v] <= CW'(ALMOST_EMPTY_LEVEL));
      bus.count_o[v*CW +: CW] = count[v];
    end
  end

  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
endmodule

// File: tb/tb_vc_fifo.sv
module tb_vc_fifo;
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  vc_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .NUM_VC(2), .VC_WIDTH(1)) if0 ();
  vc_fifo_if #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .NUM_VC(2), .VC_WIDTH(1)) if1 ();

  vc_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .NUM_VC(2), .VC_WIDTH(1),
            .ALMOST_EMPTY_LEVEL(1), .ALMOST_FULL_LEVEL(3), .FWFT(1'b0))
    dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0.slave));

  vc_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(2), .NUM_VC(2), .VC_WIDTH(1),
            .ALMOST_EMPTY_LEVEL(1), .ALMOST_FULL_LEVEL(3), .FWFT(1'b1))
    dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       we;
    logic       wvc;
    logic [7:0] wd;
    logic       re;
    logic       rvc;
    logic [7:0] ed;
    int         c0;
    int         c1;
    logic [1:0] ov;
    logic [1:0] un;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic we, logic wvc, logic [7:0] wd, logic re, logic rvc,
                              logic [7:0] ed, int c0, int c1, logic [1:0] ov, logic [1:0] un);
    vec_t r;
    r.we = we; r.wvc = wvc; r.wd = wd; r.re = re; r.rvc = rvc;
    r.ed = ed; r.c0 = c0; r.c1 = c1; r.ov = ov; r.un = un;
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected flags are derived from hand-computed per-VC counts
  // (DEPTH=4, almost_full at >=3, almost_empty at <=1).
  task automatic chk_all(string tag, logic [7:0] d, logic [1:0] fu, logic [1:0] em,
                         logic [1:0] af, logic [1:0] ae, logic [5:0] cnt,
                         logic [1:0] ov, logic [1:0] un, logic [7:0] ed,
                         int c0, int c1, logic [1:0] eov, logic [1:0] eun);
    logic [1:0] efu, eem, eaf, eae;
    efu = {c1 == 4, c0 == 4};
    eem = {c1 == 0, c0 == 0};
    eaf = {c1 >= 3, c0 >= 3};
    eae = {c1 <= 1, c0 <= 1};
    chk({tag, " data"}, d, ed);
    chk({tag, " count"}, cnt, {3'(c1), 3'(c0)});
    chk({tag, " full"}, fu, efu);
    chk({tag, " empty"}, em, eem);
    chk({tag, " afull"}, af, eaf);
    chk({tag, " aempty"}, ae, eae);
    chk({tag, " ovf"}, ov, eov);
    chk({tag, " unf"}, un, eun);
  endtask

  task automatic chk0(string tag, logic [7:0] ed, int c0, int c1, logic [1:0] eov, logic [1:0] eun);
    chk_all(tag, if0.data_o, if0.full_o, if0.empty_o, if0.almost_full_o, if0.almost_empty_o,
            if0.count_o, if0.overflow_o, if0.underflow_o, ed, c0, c1, eov, eun);
  endtask

  task automatic chk1(string tag, logic [7:0] ed, int c0, int c1, logic [1:0] eov, logic [1:0] eun);
    chk_all(tag, if1.data_o, if1.full_o, if1.empty_o, if1.almost_full_o, if1.almost_empty_o,
            if1.count_o, if1.overflow_o, if1.underflow_o, ed, c0, c1, eov, eun);
  endtask

  task automatic drive0(logic we, logic wvc, logic [7:0] wd, logic re, logic rvc);
    if0.wr_en_i = we; if0.wr_vc_i = wvc; if0.data_i = wd;
    if0.rd_en_i = re; if0.rd_vc_i = rvc;
  endtask

  task automatic drive1(logic we, logic wvc, logic [7:0] wd, logic re, logic rvc);
    if1.wr_en_i = we; if1.wr_vc_i = wvc; if1.data_i = wd;
    if1.rd_en_i = re; if1.rd_vc_i = rvc;
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  initial begin
    logic       wvc, rvc, do_rd;
    logic [7:0] wd, exp_d;

    rst_i = 1'b1;
    drive0(0, 0, 8'h00, 0, 0);
    drive1(0, 0, 8'h00, 0, 0);

    // reset state, then idle
    step();
    step();
    rst_i = 1'b0;
    chk0("reset0", 8'h00, 0, 0, 2'b00, 2'b00);
    chk1("reset1", 8'h00, 0, 0, 2'b00, 2'b00);

    // FWFT=0 directed table: fill/overflow, drain/underflow, full and empty w+r
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 1, 8'h11, 0, 0, 8'h00, 0, 1, 2'b00, 2'b00));
    vq.push_back(mk(1, 1, 8'h22, 0, 0, 8'h00, 0, 2, 2'b00, 2'b00));
    vq.push_back(mk(1, 1, 8'h33, 0, 0, 8'h00, 0, 3, 2'b00, 2'b00));
    vq.push_back(mk(1, 1, 8'h44, 0, 0, 8'h00, 0, 4, 2'b00, 2'b00));
    vq.push_back(mk(1, 1, 8'h55, 0, 0, 8'h00, 0, 4, 2'b10, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 4, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 8'h11, 0, 3, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 8'h22, 0, 2, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 8'h33, 0, 1, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 8'h44, 0, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 1, 8'h44, 0, 0, 2'b00, 2'b10));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'h44, 0, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 0, 8'hA1, 0, 0, 8'h44, 1, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 0, 8'hA2, 0, 0, 8'h44, 2, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 0, 8'hA3, 0, 0, 8'h44, 3, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 0, 8'hA4, 0, 0, 8'h44, 4, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 0, 8'h55, 1, 0, 8'hA1, 4, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 0, 0, 8'hA1, 4, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA2, 3, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA3, 2, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'hA4, 1, 0, 2'b00, 2'b00));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'h55, 0, 0, 2'b00, 2'b00));
    vq.push_back(mk(1, 0, 8'h66, 1, 0, 8'h55, 1, 0, 2'b00, 2'b01));
    vq.push_back(mk(0, 0, 8'h00, 1, 0, 8'h66, 0, 0, 2'b00, 2'b00));

    for (int i = 0; i < vq.size(); i++) begin
      drive0(vq[i].we, vq[i].wvc, vq[i].wd, vq[i].re, vq[i].rvc);
      step();
      chk0($sformatf("vec%0d", i), vq[i].ed, vq[i].c0, vq[i].c1, vq[i].ov, vq[i].un);
    end

    // interleaved write/read on alternating VCs; pointers wrap several times
    for (int k = 0; k < 26; k++) begin
      wvc   = k[0];
      rvc   = ~k[0];
      wd    = (wvc ? 8'hB0 : 8'hA0) + 8'(k >> 1);
      do_rd = (k >= 4);
      exp_d = if0.data_o;
      if (do_rd) exp_d = rvc ? q1.pop_front() : q0.pop_front();
      if (wvc) q1.push_back(wd); else q0.push_back(wd);
      drive0(1, wvc, wd, do_rd, rvc);
      step();
      chk($sformatf("ilv%0d data", k), if0.data_o, exp_d);
      chk($sformatf("ilv%0d count", k), if0.count_o, {3'(q1.size()), 3'(q0.size())});
    end
    for (int v = 0; v < 2; v++) begin
      while ((v == 0 ? q0.size() : q1.size()) > 0) begin
        exp_d = (v == 0) ? q0.pop_front() : q1.pop_front();
        drive0(0, 0, 8'h00, 1, v[0]);
        step();
        chk($sformatf("drain%0d data", v), if0.data_o, exp_d);
      end
    end
    drive0(0, 0, 8'h00, 0, 0);
    step();
    chk0("drained", exp_d, 0, 0, 2'b00, 2'b00);

    // FWFT=1: head visible without a read, zero for an empty VC
    drive1(1, 0, 8'h77, 0, 1);
    step();
    drive1(0, 0, 8'h00, 0, 0);
    #1;
    chk1("fwft show", 8'h77, 1, 0, 2'b00, 2'b00);
    if1.rd_vc_i = 1'b1;
    #1;
    chk("fwft empty vc data", if1.data_o, 8'h00);
    drive1(1, 0, 8'h78, 0, 0);
    step();
    drive1(1, 0, 8'h79, 0, 0);
    step();
    drive1(0, 0, 8'h00, 0, 0);
    chk1("fwft three", 8'h77, 3, 0, 2'b00, 2'b00);

    // reset while VC0 holds 3 entries, with a competing write
    rst_i = 1'b1;
    drive1(1, 0, 8'h99, 0, 0);
    step();
    rst_i = 1'b0;
    drive1(0, 0, 8'h00, 0, 0);
    chk1("fwft reset", 8'h00, 0, 0, 2'b00, 2'b00);

    // pop of the shown word, then underflow on empty VC1
    drive1(1, 0, 8'h81, 0, 0);
    step();
    drive1(1, 0, 8'h82, 0, 0);
    step();
    drive1(0, 0, 8'h00, 1, 0);
    #1;
    chk("fwft pre-pop data", if1.data_o, 8'h81);
    step();
    drive1(0, 0, 8'h00, 0, 0);
    chk1("fwft post-pop", 8'h82, 1, 0, 2'b00, 2'b00);
    drive1(0, 0, 8'h00, 1, 1);
    step();
    drive1(0, 0, 8'h00, 0, 0);
    chk("fwft unf pulse", if1.underflow_o, 2'b10);
    step();
    chk("fwft unf clear", if1.underflow_o, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vc_fifo.md
# vc_fifo

Multi-channel (virtual-channel) input buffer for the mesh switch: one write port and one read port shared by NUM_VC independent circular FIFOs, each 2**DEPTH_WIDTH entries deep. Per-VC occupancy counters use every slot. Per-VC full, empty, almost-full, almost-empty and count outputs feed the switch allocator. A parameter selects registered-read or first-word-fall-through output.

## Interface
- DATA_WIDTH, 8, flit width in bits
- DEPTH_WIDTH, 2, log2 of per-VC depth; DEPTH = 2**DEPTH_WIDTH
- NUM_VC, 2, number of virtual channels, 1..16
- VC_WIDTH, 1, width of VC select ports; must satisfy 2**VC_WIDTH >= NUM_VC
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserted when count <= level
- ALMOST_FULL_LEVEL, 3, almost_full asserted when count >= level
- FWFT, 0, 0 = registered read data, 1 = first-word-fall-through
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- wr_en_i  in  1  write request
- wr_vc_i  in  VC_WIDTH  target VC of the write
- data_i  in  DATA_WIDTH  write data
- rd_en_i  in  1  read request
- rd_vc_i  in  VC_WIDTH  source VC of the read
- data_o  out  DATA_WIDTH  read data
- full_o  out  NUM_VC  per-VC full, count == DEPTH
- empty_o  out  NUM_VC  per-VC empty, count == 0
- almost_full_o  out  NUM_VC  per-VC almost full
- almost_empty_o  out  NUM_VC  per-VC almost empty
- count_o  out  NUM_VC*(DEPTH_WIDTH+1)  per-VC occupancy; VC v in bits [v*(DEPTH_WIDTH+1) +: DEPTH_WIDTH+1]
- overflow_o  out  NUM_VC  one-cycle pulse: write rejected on that VC
- underflow_o  out  NUM_VC  one-cycle pulse: read rejected on that VC

## Operation
- Each VC has storage [DEPTH], wr_ptr and rd_ptr of DEPTH_WIDTH bits each, and count of DEPTH_WIDTH+1 bits. Pointers wrap modulo DEPTH by natural overflow. All DEPTH slots are usable.
- A write is accepted when wr_en_i is high, wr_vc_i < NUM_VC, and either count[wr_vc] < DEPTH, or an accepted read on the same VC occurs in the same cycle. On acceptance: store at wr_ptr, then wr_ptr+1.
- A read is accepted when rd_en_i is high, rd_vc_i < NUM_VC and count[rd_vc] > 0. On acceptance: rd_ptr+1. A write to an empty VC is never bypassed to a same-cycle read.
- Rejected write: storage, pointers and count unchanged; overflow_o[wr_vc] pulses on the next cycle. Rejected read: same rule, with underflow_o[rd_vc].
- A VC index >= NUM_VC is ignored silently: no state change, no flag.
- Count update per VC: +1 on accepted write only, -1 on accepted read only, unchanged if both or neither.
- Flags are combinational from the registered count: full = (count == DEPTH), empty = (count == 0), almost_full = (count >= ALMOST_FULL_LEVEL), almost_empty = (count <= ALMOST_EMPTY_LEVEL).
- FWFT=0: data_o is a register loaded with the head of rd_vc on an accepted read, and holds otherwise, including on a rejected read.
- FWFT=1: data_o = storage[rd_vc][rd_ptr[rd_vc]], combinational on rd_vc_i. data_o is 0 when that VC is empty or rd_vc_i >= NUM_VC. An accepted read pops the shown word.
- Reset applies to all VCs: pointers 0, counts 0, data_o register 0, pulse flags 0. Storage contents are not cleared; they are unobservable while empty. Reset wins over any same-cycle write or read.

## Timing
- Reset values: data_o 0, full_o 0, empty_o all 1, almost_empty_o all 1, almost_full_o 0 (all 1 if ALMOST_FULL_LEVEL == 0), count_o 0, overflow_o 0, underflow_o 0.
- Write latency: a word written in cycle N is counted and readable from cycle N+1.
- FWFT=0: read accepted in cycle N gives data_o valid from cycle N+1.
- FWFT=1: head word is visible in the same cycle that rd_vc_i selects it.
- Throughput: one write and one read per cycle, to the same or different VCs, sustained indefinitely.
- Full + write + read on the same VC is accepted, count stays DEPTH. Empty + write + read on the same VC: read rejected (underflow), write accepted, count becomes 1.
- overflow_o and underflow_o are high for exactly one cycle per rejected request.

## Test plan
- Reset, then idle: empty_o=2'b11, count_o=0, almost_empty_o=2'b11, data_o=0, no flag pulses.
- NUM_VC=2, DEPTH=4: write 0x11,0x22,0x33,0x44 to VC1 -> full_o=2'b10, count VC1=4, almost_full_o[1]=1 from the 3rd write. Fifth write -> overflow_o[1] pulses once, count stays 4.
- FWFT=0: read VC1 four times -> data_o 0x11,0x22,0x33,0x44 each one cycle after its read. Fifth read -> underflow_o[1] pulse, data_o holds 0x44.
- Interleaved writes to VC0 (0xA0..) and VC1 (0xB0..) with 3 pointer wraps -> each VC reads back in its own order, no cross-channel leakage, no data loss.
- VC0 full, simultaneous write 0x55 and read -> old head out, count 4 unchanged, no overflow. VC0 empty, simultaneous write+read -> underflow_o[0] pulse, count 1.
- FWFT=1: write 0x77 to VC0, set rd_vc_i=0 next cycle -> data_o=0x77 with no read issued; assert rst_i while VC0 holds 3 entries -> count 0, empty_o[0]=1 on the next cycle.
